// File: rtl/aqalu_pkg.sv
// Shared opcode encodings and constants for the aqalu block.
package aqalu_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_MOD  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_NAND = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1001;
   localparam logic [3:0] OP_XNOR = 4'b1010;
   localparam logic [3:0] OP_NOT  = 4'b1011;
   localparam logic [3:0] OP_SHL  = 4'b1100;
   localparam logic [3:0] OP_SHR  = 4'b1101;
   localparam logic [3:0] OP_CMP  = 4'b1110;
   localparam logic [3:0] OP_TIME = 4'b1111;

   localparam logic [7:0] DIV_BY_ZERO = 8'hFF;

endpackage

// File: rtl/aqalu_sec_timer.sv
// Free-running seconds counter: a prescaler divides the clock down to one
// tick per CLKS_PER_SEC edges, and each tick advances the seconds count.
module aqalu_sec_timer #(
   parameter int CLKS_PER_SEC = 10_000_000,
   parameter int SEC_WIDTH    = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   output logic [SEC_WIDTH-1:0] seconds
);

   localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [PW-1:0] TC = PW'(CLKS_PER_SEC - 1);

   logic [PW-1:0] pre;

   // Seconds advance on the same edge the prescaler wraps, so the first
   // tick lands on the CLKS_PER_SEC-th edge after reset release.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre     <= '0;
         seconds <= '0;
      end else if (pre == TC) begin
         pre     <= '0;
         seconds <= seconds + SEC_WIDTH'(1);
      end else begin
         pre     <= pre + PW'(1);
      end
   end

endmodule

// File: rtl/aqalu.sv
// 2-bit ALU with an 8-bit zero-extended result; opcode 1111 reads the
// elapsed-seconds timer instead of an arithmetic function.
module aqalu
   import aqalu_pkg::*;
#(
   parameter int CLKS_PER_SEC = 10_000_000,
   parameter int SEC_WIDTH    = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] A,
   input  logic [1:0] B,
   input  logic [3:0] Opcode,
   output logic [7:0] Output
);

   logic [SEC_WIDTH-1:0] seconds;
   logic [7:0]           sec8;
   logic [7:0]           a8, b8;
   logic [7:0]           res;

   aqalu_sec_timer #(
      .CLKS_PER_SEC (CLKS_PER_SEC),
      .SEC_WIDTH    (SEC_WIDTH)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .seconds (seconds)
   );

   generate
      if (SEC_WIDTH >= 8) begin : g_sec_trunc
         assign sec8 = seconds[7:0];
      end else begin : g_sec_ext
         assign sec8 = {{(8-SEC_WIDTH){1'b0}}, seconds};
      end
   endgenerate

   assign a8 = {6'b0, A};
   assign b8 = {6'b0, B};

   // Bitwise-inverting ops stay 2 bits wide before zero-extension so the
   // upper result bits never pick up inverted zeros.
   always_comb begin
      res = 8'h00;
      case (Opcode)
         OP_ADD:  res = a8 + b8;
         OP_SUB:  res = a8 - b8;
         OP_MUL:  res = a8 * b8;
         OP_DIV:  res = (B == 2'd0) ? DIV_BY_ZERO : a8 / b8;
         OP_MOD:  res = (B == 2'd0) ? DIV_BY_ZERO : a8 % b8;
         OP_AND:  res = {6'b0, A & B};
         OP_OR:   res = {6'b0, A | B};
         OP_XOR:  res = {6'b0, A ^ B};
         OP_NAND: res = {6'b0, ~(A & B)};
         OP_NOR:  res = {6'b0, ~(A | B)};
         OP_XNOR: res = {6'b0, ~(A ^ B)};
         OP_NOT:  res = {6'b0, ~A};
         OP_SHL:  res = a8 << B;
         OP_SHR:  res = a8 >> B;
         OP_CMP:  res = {5'b0, (A > B), (A == B), (A < B)};
         OP_TIME: res = sec8;
         default: res = 8'h00;
      endcase
   end

   assign Output = res;

endmodule

// File: tb/tb_aqalu.sv
// Directed self-checking bench for aqalu, run with a 4-clock second so the
// timer, wrap and mid-count reset paths fit in a short simulation.
module tb_aqalu;
   import aqalu_pkg::*;

   logic       clock;
   logic       reset;
   logic [1:0] A, B;
   logic [3:0] Opcode;
   logic [7:0] Output;

   int checks   = 0;
   int failures = 0;

   aqalu #(.CLKS_PER_SEC(4), .SEC_WIDTH(8)) dut (
      .clock  (clock),
      .reset  (reset),
      .A      (A),
      .B      (B),
      .Opcode (Opcode),
      .Output (Output)
   );

   initial begin
      clock = 1'b0;
      forever #50 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [7:0] exp);
      checks++;
      assert (Output === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, Output, exp);
      end
   endtask

   task automatic vec(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b,
                      input logic [7:0] exp, input string tag);
      Opcode = op; A = a; B = b;
      #1;
      chk(tag, exp);
   endtask

   task automatic edge_then_time(input int n, input logic [7:0] exp, input string tag);
      repeat (n) @(posedge clock);
      #1;
      Opcode = OP_TIME;
      #1;
      chk(tag, exp);
   endtask

   initial begin
      reset = 1'b1; A = 2'd0; B = 2'd0; Opcode = OP_TIME;
      #1;
      chk("rst_time", 8'h00);
      vec(OP_ADD, 2'd3, 2'd3, 8'd6, "rst_add33");
      #8;
      reset = 1'b0;                          // released at t=10
      vec(OP_TIME, 2'd0, 2'd0, 8'h00, "post_rst_time");

      // ALU table, hand-computed
      vec(OP_ADD,  2'd1, 2'd2, 8'd3,   "add12");
      vec(OP_ADD,  2'd0, 2'd0, 8'd0,   "add00");
      vec(OP_SUB,  2'd1, 2'd2, 8'hFF,  "sub12");
      vec(OP_SUB,  2'd3, 2'd1, 8'd2,   "sub31");
      vec(OP_SUB,  2'd0, 2'd3, 8'hFD,  "sub03");
      vec(OP_MUL,  2'd3, 2'd3, 8'd9,   "mul33");
      vec(OP_MUL,  2'd2, 2'd3, 8'd6,   "mul23");
      vec(OP_DIV,  2'd3, 2'd0, 8'hFF,  "div30");
      vec(OP_DIV,  2'd3, 2'd2, 8'd1,   "div32");
      vec(OP_DIV,  2'd0, 2'd3, 8'd0,   "div03");
      vec(OP_MOD,  2'd3, 2'd0, 8'hFF,  "mod30");
      vec(OP_MOD,  2'd3, 2'd2, 8'd1,   "mod32");
      vec(OP_MOD,  2'd2, 2'd3, 8'd2,   "mod23");
      vec(OP_AND,  2'd3, 2'd1, 8'd1,   "and31");
      vec(OP_AND,  2'd2, 2'd1, 8'd0,   "and21");
      vec(OP_OR,   2'd2, 2'd1, 8'd3,   "or21");
      vec(OP_XOR,  2'd3, 2'd1, 8'd2,   "xor31");
      vec(OP_XOR,  2'd2, 2'd2, 8'd0,   "xor22");
      vec(OP_NAND, 2'd3, 2'd3, 8'd0,   "nand33");
      vec(OP_NAND, 2'd2, 2'd1, 8'd3,   "nand21");
      vec(OP_NOR,  2'd0, 2'd0, 8'd3,   "nor00");
      vec(OP_NOR,  2'd2, 2'd0, 8'd1,   "nor20");
      vec(OP_XNOR, 2'd1, 2'd1, 8'd3,   "xnor11");
      vec(OP_XNOR, 2'd2, 2'd1, 8'd0,   "xnor21");
      vec(OP_NOT,  2'd1, 2'd0, 8'd2,   "not1");
      vec(OP_NOT,  2'd0, 2'd3, 8'd3,   "not0");
      vec(OP_SHL,  2'd3, 2'd3, 8'd24,  "shl33");
      vec(OP_SHL,  2'd1, 2'd2, 8'd4,   "shl12");
      vec(OP_SHL,  2'd2, 2'd0, 8'd2,   "shl20");
      vec(OP_SHR,  2'd3, 2'd1, 8'd1,   "shr31");
      vec(OP_SHR,  2'd2, 2'd3, 8'd0,   "shr23");
      vec(OP_SHR,  2'd3, 2'd0, 8'd3,   "shr30");
      vec(OP_CMP,  2'd2, 2'd1, 8'h04,  "cmp21");
      vec(OP_CMP,  2'd1, 2'd1, 8'h02,  "cmp11");
      vec(OP_CMP,  2'd0, 2'd3, 8'h01,  "cmp03");

      // First second lands on the 4th edge after release
      edge_then_time(3, 8'd0, "sec_before_1");
      edge_then_time(1, 8'd1, "sec_1");
      edge_then_time(4, 8'd2, "sec_2");

      // Opcode churn while counting: 12 edges = 3 seconds
      for (int i = 0; i < 12; i++) begin
         @(posedge clock);
         #1;
         Opcode = (i % 2 == 0) ? OP_ADD : OP_XOR;
         A = 2'd2; B = 2'd1;
         #1;
         chk("churn_alu", (i % 2 == 0) ? 8'd3 : 8'd3);
      end
      Opcode = OP_TIME;
      #1;
      chk("sec_after_churn", 8'd5);

      // Mid-count async reset: prescaler at 2, reset between edges
      repeat (2) @(posedge clock);
      #1;
      chk("sec5_prereset", 8'd5);
      #19;
      reset = 1'b1;
      #1;
      chk("async_clear", 8'd0);
      #9;
      reset = 1'b0;
      edge_then_time(3, 8'd0, "resume_before_1");
      edge_then_time(1, 8'd1, "resume_1");

      // Wrap: 256 seconds of 4 edges from a fresh reset
      #20;
      reset = 1'b1;
      #5;
      reset = 1'b0;
      edge_then_time(256*4 - 1, 8'd255, "sec_255");
      edge_then_time(1, 8'd0, "wrap_0");
      edge_then_time(4, 8'd1, "wrap_1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
